bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, giving the address width.
REQ-002 The block SHALL have parameter DW, default 32, giving the data width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Ports inst_req in 1, inst_addr in AW SHALL carry the instruction-fetch read request.
REQ-006 Ports inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out DW SHALL carry the instruction-side handshake and read data.
REQ-007 Ports data_req in 1, data_wr in 1, data_size in 2, data_addr in AW, data_wdata in DW SHALL carry the load/store request.
REQ-008 Ports data_addr_ok out 1, data_data_ok out 1, data_rdata out DW SHALL carry the data-side handshake and read data.
REQ-009 Ports mem_req out 1, mem_wr out 1, mem_size out 2, mem_addr out AW, mem_wdata out DW SHALL drive the single shared memory port.
REQ-010 Ports mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in DW SHALL return the shared port handshake and read data.
REQ-011 Port owner  out 1  SHALL indicate the current grant (0 = inst, 1 = data); it is the select for the request-field multiplexer.

Function
REQ-012 The FSM SHALL have states IDLE, ADDR, WAIT; at most one transaction is outstanding on the shared port.
REQ-013 In IDLE with exactly one requester asserting req, the FSM SHALL grant it, load owner, and enter ADDR on the next edge (1-cycle grant latency).
REQ-014 In IDLE with both requesters asserting req: round-robin; the requester not granted last SHALL win; last_owner resets to inst, so data wins the first tie.
REQ-015 In ADDR: mem_req = 1; mem_wr, mem_size, mem_addr and mem_wdata SHALL be taken combinationally from the owner's inputs. For inst: mem_wr = 0, mem_size = 2'b10, mem_wdata = 0.
REQ-016 mem_addr_ok SHALL be forwarded combinationally only to the owner's addr_ok; the non-owner's addr_ok is 0.
REQ-017 In ADDR on mem_addr_ok = 1 with mem_data_ok = 0, the FSM SHALL enter WAIT and mem_req SHALL drop the next cycle.
REQ-018 In ADDR with mem_addr_ok and mem_data_ok both 1, the transaction SHALL complete that cycle: owner's data_ok = 1, FSM returns to IDLE.
REQ-019 In WAIT, mem_data_ok SHALL be forwarded combinationally to the owner's data_ok; the FSM SHALL return to IDLE on the same edge and update last_owner.
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata; only the owner's data_ok qualifies it.
REQ-021 If the owner deasserts req while in ADDR, the arbiter SHALL still hold mem_req until mem_addr_ok; requesters are required to hold req and fields stable until addr_ok.
REQ-022 mem_data_ok in IDLE, and mem_addr_ok outside ADDR, SHALL be ignored; no ok output asserts.
REQ-023 A requester whose req arrives during ADDR or WAIT SHALL wait; its earliest grant is the IDLE cycle after completion, so back-to-back transactions have one IDLE bubble.
REQ-024 Any ok output SHALL be high only in the cycle its mem_* counterpart is high and that requester owns the port.

Reset
REQ-025 On resetn = 0: FSM = IDLE, owner = 0, last_owner = inst; mem_req, all addr_ok and all data_ok outputs = 0. This takes effect immediately, without waiting for clk.
REQ-026 A reset during ADDR or WAIT SHALL abandon the transaction; any later mem_data_ok for it is ignored per REQ-022.
REQ-027 After resetn rises, the first grant SHALL occur no earlier than the first rising clk edge with resetn = 1.

Verification
REQ-028 Single fetch: inst_req = 1, addr 0xBFC00000; mem_addr_ok on cycle 2, mem_data_ok = 1 with rdata 0x3C1D0001 on cycle 4. Required: mem_addr = 0xBFC00000 and mem_wr = 0 while in ADDR; inst_data_ok = 1 and inst_rdata = 0x3C1D0001 on cycle 4; data_* ok outputs stay 0.
REQ-029 Tie after reset: inst_req and data_req both 1 (store, addr 0x80001000, wdata 0xDEADBEEF, size 2'b10). Required: data granted first with mem_wr = 1, mem_wdata = 0xDEADBEEF; inst granted next after one IDLE cycle.
REQ-030 Continuous contention over 4 transactions: both req held high. Required: owner sequence 1, 0, 1, 0; no starvation of either requester.
REQ-031 Same-cycle handshake: mem_addr_ok = mem_data_ok = 1 on the first ADDR cycle. Required: the owner's addr_ok and data_ok are both 1 that cycle; FSM is in IDLE next cycle; WAIT is never entered.
REQ-032 Reset mid-WAIT: resetn = 0 for 2 cycles, then a stray mem_data_ok = 1. Required: mem_req = 0 and all ok outputs 0 throughout; the stray response produces no ok output.
REQ-033 Spurious response: mem_data_ok = 1 in IDLE with no request pending. Required: inst_data_ok = data_data_ok = 0 and no state change.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for a single shared memory port.
// An instruction-fetch master and a load/store master compete for one
// request/response channel. One transaction is outstanding at a time.
// Simultaneous requests are resolved round-robin.
module bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,

    // instruction-fetch side (read only)
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    // load/store side
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    // shared memory port
    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata,

    // current grant: 0 = inst, 1 = data
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    // requester served most recently; breaks ties in favour of the other one
    logic   last_owner_q, last_owner_d;

    // State register; the async reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state logic and handshake steering to the owning requester.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req      = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state_q)
            S_IDLE: begin
                // memory responses arriving here belong to nobody and are dropped
                if (inst_req || data_req) begin
                    state_d = S_ADDR;
                    if (inst_req && data_req) begin
                        owner_d = ~last_owner_q;
                    end else begin
                        owner_d = data_req;
                    end
                end
            end

            S_ADDR: begin
                // request is held even if the owner lets go of req early
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    inst_addr_ok = ~owner_q;
                    data_addr_ok = owner_q;
                    if (mem_data_ok) begin
                        inst_data_ok = ~owner_q;
                        data_data_ok = owner_q;
                        state_d      = S_IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_data_ok) begin
                    inst_data_ok = ~owner_q;
                    data_data_ok = owner_q;
                    state_d      = S_IDLE;
                    last_owner_d = owner_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request-field multiplexer; the fetch side is always a word read.
    always_comb begin
        if (owner_q) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = 1'b0;
            mem_size  = 2'b10;
            mem_addr  = inst_addr;
            mem_wdata = '0;
        end
    end

    assign owner      = owner_q;
    // read data is broadcast; each side's data_ok says whether it is theirs
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
